// File: rtl/gpio_mode_sequencer_if.sv
// Mode-change request channel for gpio_mode_sequencer.
// The master issues requests; the slave returns ready, busy and the done/err pulses.
interface gpio_mode_sequencer_if #(
   parameter int unsigned NUM_PADS = 4
);
   localparam int unsigned PW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;

   logic          req_valid;
   logic          req_ready;
   logic [PW-1:0] req_pad;
   logic [2:0]    req_mode;
   logic          done;
   logic          err;
   logic          busy;

   modport master (
      output req_valid, req_pad, req_mode,
      input  req_ready, done, err, busy
   );

   modport slave (
      input  req_valid, req_pad, req_mode,
      output req_ready, done, err, busy
   );
endinterface

// File: rtl/gpio_mode_sequencer.sv
// Glitch-safe runtime drive-mode sequencer for Openframe GPIO pads (park hi-z, apply, commit).
// Optional macro GPIO_SEQ_LOCK_EN adds a sticky request lock (lock_req / locked).
module gpio_mode_sequencer #(
   parameter int unsigned NUM_PADS      = 4,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter logic [2:0]  RESET_MODE    = 3'd1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   gpio_mode_sequencer_if.slave  req_if,
`ifdef GPIO_SEQ_LOCK_EN
   input  logic                  lock_req,
   output logic                  locked,
`endif
   output logic [3*NUM_PADS-1:0] mode_rd,
   input  logic [NUM_PADS-1:0]   io_out,
   input  logic [NUM_PADS-1:0]   io_oeb,
   output logic [3*NUM_PADS-1:0] gpio_dm,
   output logic [NUM_PADS-1:0]   gpio_inp_dis,
   output logic [NUM_PADS-1:0]   gpio_oeb_out,
   output logic [NUM_PADS-1:0]   gpio_out_val
);
   localparam int unsigned PW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;
   localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PARK,
      S_APPLY,
      S_COMMIT
   } state_t;

   typedef enum logic [2:0] {
      M_ANALOG   = 3'd0,
      M_INPUT    = 3'd1,
      M_INPUT_PD = 3'd2,
      M_INPUT_PU = 3'd3,
      M_OUTPUT   = 3'd4,
      M_BIDIR    = 3'd5
   } mode_t;

   typedef struct packed {
      logic [2:0] dm;
      logic       inp_dis;
      logic       oeb;
      logic       out;
   } pad_cfg_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [PW-1:0] r_pad;
   mode_t         r_tmode;
   mode_t         r_mode [NUM_PADS];
   logic          r_done;
   logic          r_err;

   logic          w_xfer;
   logic          w_bad;
   logic          w_same;
   logic          w_locked;
   pad_cfg_t      w_cfg;
   pad_cfg_t      w_tgt;

   function automatic pad_cfg_t f_map(input mode_t m, input logic d_out, input logic d_oeb);
      pad_cfg_t c;
      case (m)
         M_INPUT:    c = '{dm: 3'b001, inp_dis: 1'b0, oeb: 1'b1,  out: 1'b0};
         M_INPUT_PD: c = '{dm: 3'b011, inp_dis: 1'b0, oeb: 1'b0,  out: 1'b0};
         M_INPUT_PU: c = '{dm: 3'b010, inp_dis: 1'b0, oeb: 1'b0,  out: 1'b1};
         M_OUTPUT:   c = '{dm: 3'b110, inp_dis: 1'b1, oeb: 1'b0,  out: d_out};
         M_BIDIR:    c = '{dm: 3'b110, inp_dis: 1'b0, oeb: d_oeb, out: d_out};
         default:    c = '{dm: 3'b000, inp_dis: 1'b1, oeb: 1'b1,  out: 1'b0};
      endcase
      return c;
   endfunction

`ifdef GPIO_SEQ_LOCK_EN
   logic r_locked;
   assign locked   = r_locked;
   assign w_locked = r_locked;
`else
   assign w_locked = 1'b0;
`endif

   assign req_if.req_ready = (r_state == S_IDLE);
   assign req_if.busy      = (r_state != S_IDLE);
   assign req_if.done      = r_done;
   assign req_if.err       = r_err;

   assign w_xfer = req_if.req_valid && (r_state == S_IDLE);
   assign w_bad  = (req_if.req_mode > 3'd5) || (32'(req_if.req_pad) >= NUM_PADS) || w_locked;
   // Only consulted when w_bad is clear, so the pad index is in range here.
   assign w_same = (r_mode[req_if.req_pad] == mode_t'(req_if.req_mode));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_pad   <= '0;
         r_tmode <= mode_t'(RESET_MODE);
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         for (int unsigned n = 0; n < NUM_PADS; n++) begin
            r_mode[n] <= mode_t'(RESET_MODE);
         end
`ifdef GPIO_SEQ_LOCK_EN
         r_locked <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
`ifdef GPIO_SEQ_LOCK_EN
         if ((r_state == S_IDLE) && lock_req) begin
            r_locked <= 1'b1;
         end
`endif
         case (r_state)
            S_IDLE: begin
               if (w_xfer) begin
                  if (w_bad) begin
                     r_err <= 1'b1;
                  end else if (w_same) begin
                     r_done <= 1'b1;
                  end else begin
                     r_pad   <= req_if.req_pad;
                     r_tmode <= mode_t'(req_if.req_mode);
                     r_cnt   <= RELOAD;
                     r_state <= S_PARK;
                  end
               end
            end
            S_PARK: begin
               if (r_cnt == '0) begin
                  r_cnt   <= RELOAD;
                  r_state <= S_APPLY;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_APPLY: begin
               if (r_cnt == '0) begin
                  r_done  <= 1'b1;
                  r_state <= S_COMMIT;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_COMMIT: begin
               r_mode[r_pad] <= r_tmode;
               r_state       <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      mode_rd = '0;
      for (int unsigned n = 0; n < NUM_PADS; n++) begin
         mode_rd[3*n +: 3] = r_mode[n];
      end
   end

   // Target pad is held hi-z while parked and while the new drive mode settles.
   always_comb begin
      gpio_dm      = '0;
      gpio_inp_dis = '0;
      gpio_oeb_out = '0;
      gpio_out_val = '0;
      w_cfg        = '0;
      w_tgt        = f_map(r_tmode, 1'b0, 1'b1);
      for (int unsigned n = 0; n < NUM_PADS; n++) begin
         w_cfg = f_map(r_mode[n], io_out[n], io_oeb[n]);
         if (((r_state == S_PARK) || (r_state == S_APPLY)) && (32'(r_pad) == n)) begin
            if (r_state == S_PARK) begin
               w_cfg.dm      = 3'b001;
               w_cfg.inp_dis = 1'b0;
            end else begin
               w_cfg.dm      = w_tgt.dm;
               w_cfg.inp_dis = w_tgt.inp_dis;
            end
            w_cfg.oeb = 1'b1;
            w_cfg.out = 1'b0;
         end
         gpio_dm[3*n +: 3] = w_cfg.dm;
         gpio_inp_dis[n]   = w_cfg.inp_dis;
         gpio_oeb_out[n]   = w_cfg.oeb;
         gpio_out_val[n]   = w_cfg.out;
      end
   end
endmodule

// File: tb/tb_gpio_mode_sequencer.sv
// Directed bench for gpio_mode_sequencer: reset, sequencing, same-mode, errors, mid-sequence reset.
// Lock checks are compiled in when GPIO_SEQ_LOCK_EN is defined.
module tb_gpio_mode_sequencer;
   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   int unsigned total = 0;
   int unsigned bad   = 0;

   always #5 clk = ~clk;

   gpio_mode_sequencer_if #(.NUM_PADS(4)) rq  ();
   gpio_mode_sequencer_if #(.NUM_PADS(3)) rq3 ();

   logic [11:0] mode_rd, gpio_dm;
   logic [3:0]  io_out, io_oeb, gpio_inp_dis, gpio_oeb_out, gpio_out_val;
   logic [8:0]  mode_rd3, gpio_dm3;
   logic [2:0]  io_out3, io_oeb3, gpio_inp_dis3, gpio_oeb_out3, gpio_out_val3;
`ifdef GPIO_SEQ_LOCK_EN
   logic lock_req, locked, lock_req3, locked3;
`endif

   gpio_mode_sequencer #(
      .NUM_PADS(4), .SETTLE_CYCLES(4), .RESET_MODE(3'd1)
   ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_if       (rq),
`ifdef GPIO_SEQ_LOCK_EN
      .lock_req     (lock_req),
      .locked       (locked),
`endif
      .mode_rd      (mode_rd),
      .io_out       (io_out),
      .io_oeb       (io_oeb),
      .gpio_dm      (gpio_dm),
      .gpio_inp_dis (gpio_inp_dis),
      .gpio_oeb_out (gpio_oeb_out),
      .gpio_out_val (gpio_out_val)
   );

   gpio_mode_sequencer #(
      .NUM_PADS(3), .SETTLE_CYCLES(2), .RESET_MODE(3'd1)
   ) u_dut3 (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_if       (rq3),
`ifdef GPIO_SEQ_LOCK_EN
      .lock_req     (lock_req3),
      .locked       (locked3),
`endif
      .mode_rd      (mode_rd3),
      .io_out       (io_out3),
      .io_oeb       (io_oeb3),
      .gpio_dm      (gpio_dm3),
      .gpio_inp_dis (gpio_inp_dis3),
      .gpio_oeb_out (gpio_oeb_out3),
      .gpio_out_val (gpio_out_val3)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_pads(input string tag, input logic [11:0] dm, input logic [3:0] inp,
                             input logic [3:0] oeb, input logic [3:0] out);
      check_eq({tag, "_dm"},  gpio_dm,      dm);
      check_eq({tag, "_inp"}, gpio_inp_dis, inp);
      check_eq({tag, "_oeb"}, gpio_oeb_out, oeb);
      check_eq({tag, "_out"}, gpio_out_val, out);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns one cycle after the transfer edge (cycle T+1).
   task automatic send(input logic [1:0] pad, input logic [2:0] mode);
      rq.req_pad   = pad;
      rq.req_mode  = mode;
      rq.req_valid = 1'b1;
      tick();
      rq.req_valid = 1'b0;
   endtask

   task automatic run_req(input logic [1:0] pad, input logic [2:0] mode);
      int unsigned n;
      send(pad, mode);
      n = 0;
      while (rq.done !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      check_eq("seq_done", rq.done, 1'b1);
      check_eq("seq_latency", n, 8);
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned n;
      rq.req_valid  = 1'b0; rq.req_pad  = '0; rq.req_mode  = '0;
      rq3.req_valid = 1'b0; rq3.req_pad = '0; rq3.req_mode = '0;
      io_out = '0; io_oeb = '0; io_out3 = '0; io_oeb3 = '0;
`ifdef GPIO_SEQ_LOCK_EN
      lock_req = 1'b0; lock_req3 = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Reset state
      check_eq("rst_mode_rd", mode_rd, 12'h249);
      check_pads("rst", 12'h249, 4'h0, 4'hF, 4'h0);
      check_eq("rst_ready", rq.req_ready, 1'b1);
      check_eq("rst_busy",  rq.busy, 1'b0);
      check_eq("rst_done",  rq.done, 1'b0);
      check_eq("rst_err",   rq.err, 1'b0);
      check_eq("rst_mode_rd3", mode_rd3, 9'h049);

      // Pad 2 -> OUTPUT, cycle by cycle
      io_out = 4'hF;
      send(2'd2, 3'd4);
      for (int i = 0; i < 4; i++) begin
         check_pads("park", 12'h249, 4'h0, 4'hF, 4'h0);
         check_eq("park_busy", rq.busy, 1'b1);
         check_eq("park_done", rq.done, 1'b0);
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         check_pads("apply", 12'h389, 4'h4, 4'hF, 4'h0);
         check_eq("apply_done", rq.done, 1'b0);
         tick();
      end
      check_eq("commit_done",  rq.done, 1'b1);
      check_eq("commit_err",   rq.err, 1'b0);
      check_eq("commit_ready", rq.req_ready, 1'b0);
      tick();
      check_eq("out_ready",   rq.req_ready, 1'b1);
      check_eq("out_done",    rq.done, 1'b0);
      check_eq("out_mode_rd", mode_rd, 12'h309);
      check_pads("out", 12'h389, 4'h4, 4'hB, 4'h4);
      io_out = 4'hB;
      #1;
      check_eq("out_follow", gpio_out_val, 4'h0);

      // Pad 1 -> INPUT_PU, with an identical request held while busy
      io_out = 4'h0;
      send(2'd1, 3'd3);
      rq.req_valid = 1'b1;
      n = 0;
      while (rq.done !== 1'b1 && n < 40) begin
         check_eq("pu_held_ready", rq.req_ready, 1'b0);
         tick();
         n++;
      end
      check_eq("pu_done", rq.done, 1'b1);
      check_eq("pu_latency", n, 8);
      tick();
      check_eq("pu_mode_rd", mode_rd, 12'h319);
      check_pads("pu", 12'h391, 4'h4, 4'h9, 4'h2);
      check_eq("pu_ready", rq.req_ready, 1'b1);
      tick();
      rq.req_valid = 1'b0;
      check_eq("same_done", rq.done, 1'b1);
      check_eq("same_busy", rq.busy, 1'b0);
      check_pads("same", 12'h391, 4'h4, 4'h9, 4'h2);
      tick();
      check_eq("same_done_clr", rq.done, 1'b0);

      // Invalid modes
      send(2'd0, 3'd7);
      check_eq("m7_err", rq.err, 1'b1);
      check_eq("m7_done", rq.done, 1'b0);
      check_eq("m7_ready", rq.req_ready, 1'b1);
      check_eq("m7_mode_rd", mode_rd, 12'h319);
      send(2'd3, 3'd6);
      check_eq("m6_err", rq.err, 1'b1);
      check_eq("m6_mode_rd", mode_rd, 12'h319);
      tick();
      check_eq("err_clr", rq.err, 1'b0);

      // Out-of-range pad and last valid pad on the 3-pad instance
      rq3.req_pad = 2'd3; rq3.req_mode = 3'd4; rq3.req_valid = 1'b1;
      tick();
      rq3.req_valid = 1'b0;
      check_eq("pad3_err", rq3.err, 1'b1);
      check_eq("pad3_done", rq3.done, 1'b0);
      check_eq("pad3_ready", rq3.req_ready, 1'b1);
      check_eq("pad3_mode_rd", mode_rd3, 9'h049);
      rq3.req_pad = 2'd2; rq3.req_mode = 3'd1; rq3.req_valid = 1'b1;
      tick();
      rq3.req_valid = 1'b0;
      check_eq("pad2_done", rq3.done, 1'b1);
      check_eq("pad2_err", rq3.err, 1'b0);

      // Mid-sequence reset: pad 2 OUTPUT -> BIDIR, another request held
      io_out = 4'hF;
      send(2'd2, 3'd5);
      check_pads("park1", 12'h251, 4'h0, 4'hD, 4'h2);
      rq.req_pad = 2'd0; rq.req_mode = 3'd0; rq.req_valid = 1'b1;
      tick();
      check_eq("park2_ready", rq.req_ready, 1'b0);
      check_eq("park2_busy", rq.busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check_eq("mrst_mode_rd", mode_rd, 12'h249);
      check_eq("mrst_ready", rq.req_ready, 1'b1);
      check_eq("mrst_done", rq.done, 1'b0);
      check_pads("mrst", 12'h249, 4'h0, 4'hF, 4'h0);
      rq.req_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("mrst_no_done", rq.done, 1'b0);
         check_eq("mrst_hold_mode", mode_rd, 12'h249);
      end

      // BIDIR, ANALOG and INPUT_PD mappings
      run_req(2'd3, 3'd5);
      run_req(2'd0, 3'd0);
      run_req(2'd1, 3'd2);
      check_eq("mix_mode_rd", mode_rd, 12'hA50);
      io_oeb = 4'h7; io_out = 4'hF;
      #1;
      check_pads("mix_a", 12'hC58, 4'h1, 4'h5, 4'h8);
      io_oeb = 4'hF; io_out = 4'h7;
      #1;
      check_pads("mix_b", 12'hC58, 4'h1, 4'hD, 4'h0);

`ifdef GPIO_SEQ_LOCK_EN
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_eq("lock_init", locked, 1'b0);
      lock_req = 1'b1;
      tick();
      lock_req = 1'b0;
      check_eq("lock_set", locked, 1'b1);
      send(2'd0, 3'd5);
      check_eq("lock_err", rq.err, 1'b1);
      check_eq("lock_done", rq.done, 1'b0);
      check_eq("lock_ready", rq.req_ready, 1'b1);
      check_eq("lock_mode_rd", mode_rd, 12'h249);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
